// File: rtl/xge_link_mgr.sv
// Link bring-up and supervision for one 10GbE MAC/XAUI port: sequences MAC reset,
// programs and read-back-verifies the MAC config words, then watches lane alignment.
module xge_link_mgr #(
  parameter logic [31:0] RX_CFG        = 32'h9000_0000,
  parameter logic [31:0] TX_CFG        = 32'h1000_0000,
  parameter int          RESET_HOLD    = 64,
  parameter int          ALIGN_TIMEOUT = 1_000_000,
  parameter int          LOSS_FILTER   = 16,
  parameter int          RD_LAT        = 1,
  parameter int          MAX_RETRY     = 3,
  parameter int          AUTO_RESET    = 1
) (
  input  logic        host_clk,
  input  logic        host_reset_n,
  input  logic        restart,
  input  logic        xaui_mgt_tx_ready,
  input  logic        xaui_align_status,
  output logic        mac_reset,
  output logic [1:0]  host_opcode,
  output logic [9:0]  host_addr,
  output logic [31:0] host_wr_data,
  input  logic [31:0] host_rd_data,
  output logic        host_miim_sel,
  output logic        host_req,
  output logic        link_up,
  output logic        cfg_fail,
  output logic [3:0]  retry_cnt,
  output logic [15:0] link_loss_cnt
);

  localparam logic [9:0]  ADDR_RX    = 10'h240;
  localparam logic [9:0]  ADDR_TX    = 10'h280;
  localparam logic [1:0]  OP_WR      = 2'b01;
  localparam logic [1:0]  OP_RD      = 2'b11;
  localparam logic [31:0] HOLD_LAST  = 32'(RESET_HOLD - 2);
  localparam logic [31:0] RD_LAST    = 32'(RD_LAT - 1);
  localparam logic [31:0] ALIGN_LAST = 32'(ALIGN_TIMEOUT - 1);
  localparam logic [31:0] LOSS_LAST  = 32'(LOSS_FILTER - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_RST, ST_WAIT_TX, ST_HOLD, ST_WR_RX, ST_WR_TX, ST_RD_RX,
    ST_CHK_RX, ST_RD_TX, ST_CHK_TX, ST_WAIT_ALIGN, ST_UP, ST_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  tx_sync_q, tx_sync_d;
  logic [1:0]  align_sync_q, align_sync_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] link_loss_q, link_loss_d;
  logic        mac_reset_q, mac_reset_d;
  logic [1:0]  opcode_q, opcode_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        link_up_q, link_up_d;
  logic        cfg_fail_q, cfg_fail_d;
  logic        attempt_fail;
  logic        tx_rdy_s;
  logic        align_s;

  assign tx_rdy_s = tx_sync_q[1];
  assign align_s  = align_sync_q[1];

  // Two-stage synchronisers for the XAUI status inputs
  always_comb begin
    tx_sync_d    = {tx_sync_q[0], xaui_mgt_tx_ready};
    align_sync_d = {align_sync_q[0], xaui_align_status};
  end

  // Next-state, per-state timer, retry and link-loss bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    retry_d      = retry_q;
    link_loss_d  = link_loss_q;
    attempt_fail = 1'b0;
    case (state_q)
      ST_RST:     state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_rdy_s) state_d = ST_HOLD;
        else          state_d = ST_WAIT_TX;
      end
      ST_HOLD: begin
        if (!tx_rdy_s)               state_d = ST_WAIT_TX;
        else if (cnt_q == HOLD_LAST) state_d = ST_WR_RX;
        else                         state_d = ST_HOLD;
      end
      ST_WR_RX: state_d = ST_WR_TX;
      ST_WR_TX: state_d = ST_RD_RX;
      ST_RD_RX: state_d = ST_CHK_RX;
      ST_CHK_RX: begin
        if (cnt_q != RD_LAST)             state_d = ST_CHK_RX;
        else if (host_rd_data == RX_CFG)  state_d = ST_RD_TX;
        else                              attempt_fail = 1'b1;
      end
      ST_RD_TX: state_d = ST_CHK_TX;
      ST_CHK_TX: begin
        if (cnt_q != RD_LAST)             state_d = ST_CHK_TX;
        else if (host_rd_data == TX_CFG)  state_d = ST_WAIT_ALIGN;
        else                              attempt_fail = 1'b1;
      end
      ST_WAIT_ALIGN: begin
        if (align_s)                  state_d = ST_UP;
        else if (cnt_q == ALIGN_LAST) attempt_fail = 1'b1;
        else                          state_d = ST_WAIT_ALIGN;
      end
      ST_UP: begin
        // cnt_q doubles as the consecutive align-low counter here
        if (align_s) begin
          cnt_d = 32'd0;
        end else if (cnt_q == LOSS_LAST) begin
          link_loss_d = (link_loss_q == 16'hFFFF) ? link_loss_q : link_loss_q + 16'd1;
          state_d     = (AUTO_RESET != 0) ? ST_RST : ST_WAIT_ALIGN;
        end else begin
          state_d = ST_UP;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RST;
    endcase

    if (attempt_fail) begin
      retry_d = retry_q + 4'd1;
      state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RST;
    end else begin
      retry_d = (state_d == ST_UP) ? 4'd0 : retry_d;
    end

    if (restart) begin
      state_d = ST_RST;
      retry_d = 4'd0;
    end else begin
      state_d = state_d;
    end

    if (state_d != state_q) cnt_d = 32'd0;
    else                    cnt_d = cnt_d;
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    mac_reset_d = 1'b1;
    opcode_d    = OP_RD;
    addr_d      = 10'h000;
    wr_data_d   = 32'h0000_0000;
    link_up_d   = 1'b0;
    cfg_fail_d  = 1'b0;
    case (state_d)
      ST_WR_RX: begin
        mac_reset_d = 1'b0;
        opcode_d    = OP_WR;
        addr_d      = ADDR_RX;
        wr_data_d   = RX_CFG;
      end
      ST_WR_TX: begin
        mac_reset_d = 1'b0;
        opcode_d    = OP_WR;
        addr_d      = ADDR_TX;
        wr_data_d   = TX_CFG;
      end
      ST_RD_RX: begin
        mac_reset_d = 1'b0;
        addr_d      = ADDR_RX;
      end
      ST_RD_TX: begin
        mac_reset_d = 1'b0;
        addr_d      = ADDR_TX;
      end
      ST_CHK_RX, ST_CHK_TX, ST_WAIT_ALIGN: mac_reset_d = 1'b0;
      ST_UP: begin
        mac_reset_d = 1'b0;
        link_up_d   = 1'b1;
      end
      ST_FAIL: cfg_fail_d = 1'b1;
      default: mac_reset_d = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge host_clk or negedge host_reset_n) begin
    if (!host_reset_n) begin
      state_q      <= ST_RST;
      cnt_q        <= 32'd0;
      tx_sync_q    <= 2'b00;
      align_sync_q <= 2'b00;
      retry_q      <= 4'd0;
      link_loss_q  <= 16'd0;
      mac_reset_q  <= 1'b1;
      opcode_q     <= OP_RD;
      addr_q       <= 10'h000;
      wr_data_q    <= 32'h0000_0000;
      link_up_q    <= 1'b0;
      cfg_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_sync_q    <= tx_sync_d;
      align_sync_q <= align_sync_d;
      retry_q      <= retry_d;
      link_loss_q  <= link_loss_d;
      mac_reset_q  <= mac_reset_d;
      opcode_q     <= opcode_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      link_up_q    <= link_up_d;
      cfg_fail_q   <= cfg_fail_d;
    end
  end

  assign mac_reset     = mac_reset_q;
  assign host_opcode   = opcode_q;
  assign host_addr     = addr_q;
  assign host_wr_data  = wr_data_q;
  assign host_miim_sel = 1'b0;
  assign host_req      = 1'b0;
  assign link_up       = link_up_q;
  assign cfg_fail      = cfg_fail_q;
  assign retry_cnt     = retry_q;
  assign link_loss_cnt = link_loss_q;

endmodule
